rat_path_checker: RTL and testbench
===================================

RAT_PATH_CHECKER -- requirements
Module: rat_path_checker

Interface
REQ-001 The block SHALL have parameter MAZE_DIM, default 16, giving the maze side in cells; it is fixed at 16 for this release.
REQ-002 The block SHALL have parameter MAX_STEPS, default 256, giving the largest number of moves accepted per path.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse: clear position to (0,0) and begin checking a new path.
REQ-006 move_valid  in  1  a move is offered on move/last.
REQ-007 move  in  2  direction: 00 up (row-1), 01 right (col+1), 10 left (col-1), 11 down (row+1).
REQ-008 last  in  1  qualified by move_valid; marks the final move of the path.
REQ-009 move_ready  out  1  the checker accepts a move this cycle.
REQ-010 maze_addr  out  8  {row,col} read address to the maze memory.
REQ-011 maze_data  in  1  cell content, valid one cycle after maze_addr; 1 = wall, 0 = open.
REQ-012 busy  out  1  a path check is in progress.
REQ-013 pass  out  1  the path ended at (15,15) with no violation.
REQ-014 fail  out  1  the path was rejected.
REQ-015 err_code  out  2  00 none, 01 out of bounds, 10 wall hit, 11 wrong end or step overflow.
REQ-016 step_count  out  9  number of moves accepted and validated.
REQ-017 cur_row, cur_col  out  4 each  current rat position.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_MOVE, READ, CHECK, PASS and FAIL.
REQ-019 start SHALL, in any state including mid-path, load position (0,0), step_count 0, err_code 00, clear pass/fail, and go to WAIT_MOVE next cycle.
REQ-020 move_ready SHALL be 1 only in WAIT_MOVE; a handshake occurs when move_valid and move_ready are both 1.
REQ-021 On handshake, a target cell outside 0..15 in row or col SHALL take the FSM to FAIL with err_code 01, and the position SHALL be unchanged.
REQ-022 On an in-bounds handshake, the block SHALL latch the target and last, and go to READ, driving maze_addr={target_row,target_col}.
REQ-023 In CHECK, maze_data=1 SHALL take the FSM to FAIL with err_code 10, and the position SHALL be unchanged.
REQ-024 In CHECK with maze_data=0, the block SHALL update the position to the target and increment step_count.
REQ-025 From that CHECK, a latched last SHALL go to PASS if the new position is (15,15), otherwise to FAIL with err_code 11.
REQ-026 From that CHECK, when last is not latched, the FSM SHALL return to WAIT_MOVE.
REQ-027 Accepting a move when step_count equals MAX_STEPS-1 without last SHALL go to FAIL with err_code 11; step_count SHALL never wrap.
REQ-028 Throughput SHALL be one move per 3 cycles (WAIT_MOVE, READ, CHECK).
REQ-029 pass and fail SHALL be registered levels that are mutually exclusive and held until start or reset.
REQ-030 busy SHALL be 1 in WAIT_MOVE, READ and CHECK, and 0 otherwise.
REQ-031 maze_addr SHALL equal {cur_row,cur_col} outside READ.
REQ-032 Moves offered in IDLE, PASS or FAIL SHALL be ignored, because move_ready is 0 in those states.
REQ-033 When start and move_valid are both 1 in the same cycle, start SHALL win and the move SHALL not be accepted.

Reset
REQ-034 When rst is low, the block SHALL asynchronously force state IDLE, position (0,0), step_count 0, err_code 00, and pass, fail, busy and move_ready all 0.
REQ-035 After rst rises, the block SHALL stay in IDLE until start.

Structure
REQ-036 The move encodings, FSM state enum, err_code constants and MAZE_DIM/goal constants SHALL reside in shared package rat_pkg.
REQ-037 The next-position and bounds calculation SHALL be one combinational sub-module, rat_step_calc, with inputs row, col and move and outputs next_row, next_col and oob.
REQ-038 The block SHALL not instantiate the maze memory; the bench or top SHALL supply a 256x1 memory with a 1-cycle synchronous read.

Verification
REQ-039 Scenario 1 SHALL use an all-open maze and feed 15x down then 15x right with last on the 30th move -> pass=1, step_count=30, cur=(15,15).
REQ-040 Scenario 2 SHALL feed first move up from (0,0) -> fail=1, err_code=01, cur=(0,0), step_count=0.
REQ-041 Scenario 3 SHALL set wall at (1,0) and feed move down -> fail=1, err_code=10 three cycles after the handshake, step_count=0.
REQ-042 Scenario 4 SHALL use an open maze and feed right, down with last -> fail=1, err_code=11, cur=(1,1).
REQ-043 Scenario 5 SHALL pulse start after 5 valid moves and then replay Scenario 1 -> counters restart at 0 and pass=1 with step_count=30.
REQ-044 Scenario 6 SHALL assert rst low during READ -> all outputs are 0 immediately without a clock edge, and move_valid is ignored until start.

Source files
------------

// File: rtl/rat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rat_pkg
// Description : Shared definitions for the rat path checker. Holds the move
//               encodings, FSM state type, error codes and the maze geometry
//               and goal-cell constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rat_pkg;

    // Maze geometry; coordinates are 4 bits wide, so the maze is 16x16
    localparam int         c_maze_dim = 16;
    localparam logic [3:0] c_goal_row = 4'd15;
    localparam logic [3:0] c_goal_col = 4'd15;

    // Move direction encodings
    typedef enum logic [1:0] {
        MOVE_UP    = 2'b00,   // row - 1
        MOVE_RIGHT = 2'b01,   // col + 1
        MOVE_LEFT  = 2'b10,   // col - 1
        MOVE_DOWN  = 2'b11    // row + 1
    } move_t;

    // Checker FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MOVE = 3'd1,
        ST_READ      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_PASS      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // err_code values
    localparam logic [1:0] c_err_none = 2'b00;
    localparam logic [1:0] c_err_oob  = 2'b01;
    localparam logic [1:0] c_err_wall = 2'b10;
    localparam logic [1:0] c_err_end  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rat_step_calc.sv
`default_nettype none
// ============================================================================
// Module      : rat_step_calc
// Description : Combinational next-position and bounds calculation for one
//               rat move.
// Ports       : row, col    - current position
//               move        - direction (move_t encoding)
//               next_row/col- target position (equals current when oob)
//               oob         - target would leave the maze
// Revision    : 1.0 - initial release
// ============================================================================
module rat_step_calc
    import rat_pkg::*;
#(
    parameter int MAZE_DIM = c_maze_dim
) (
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic [1:0] move,
    output logic [3:0] next_row,
    output logic [3:0] next_col,
    output logic       oob
);

    localparam logic [3:0] c_max_idx = 4'(MAZE_DIM - 1);

    always_comb begin
        next_row = row;
        next_col = col;
        oob      = 1'b0;
        case (move_t'(move))
            MOVE_UP: begin
                if (row == 4'd0) oob = 1'b1;
                else             next_row = row - 4'd1;
            end
            MOVE_RIGHT: begin
                if (col == c_max_idx) oob = 1'b1;
                else                  next_col = col + 4'd1;
            end
            MOVE_LEFT: begin
                if (col == 4'd0) oob = 1'b1;
                else             next_col = col - 4'd1;
            end
            MOVE_DOWN: begin
                if (row == c_max_idx) oob = 1'b1;
                else                  next_row = row + 4'd1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rat_path_checker.sv
`default_nettype none
// ============================================================================
// Module      : rat_path_checker
// Description : Validates a stream of rat moves through a 16x16 maze held in
//               an external 256x1 memory (1-cycle synchronous read). Each
//               move takes WAIT_MOVE -> READ -> CHECK; the path passes when
//               its last move lands on the goal cell without violations.
// Ports       : clk, rst (async, active-low)
//               start                  - begin a new path at (0,0)
//               move_valid/move/last   - move offer, move_ready accepts it
//               maze_addr/maze_data    - maze memory read port
//               busy, pass, fail, err_code, step_count, cur_row, cur_col
// Revision    : 1.0 - initial release
// ============================================================================
module rat_path_checker
    import rat_pkg::*;
#(
    parameter int MAZE_DIM  = c_maze_dim,
    parameter int MAX_STEPS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    input  logic [1:0] move,
    input  logic       last,
    output logic       move_ready,
    output logic [7:0] maze_addr,
    input  logic       maze_data,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [1:0] err_code,
    output logic [8:0] step_count,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col
);

    localparam logic [8:0] c_last_step = 9'(MAX_STEPS - 1);

    state_t     r_state,   w_state_nxt;
    logic [3:0] r_row,     w_row_nxt;
    logic [3:0] r_col,     w_col_nxt;
    logic [3:0] r_tgt_row, w_tgt_row_nxt;
    logic [3:0] r_tgt_col, w_tgt_col_nxt;
    logic       r_last,    w_last_nxt;
    logic [8:0] r_steps,   w_steps_nxt;
    logic [1:0] r_err,     w_err_nxt;
    logic       r_pass,    w_pass_nxt;
    logic       r_fail,    w_fail_nxt;

    logic [3:0] w_step_row;
    logic [3:0] w_step_col;
    logic       w_oob;

    rat_step_calc #(
        .MAZE_DIM (MAZE_DIM)
    ) u_step_calc (
        .row      (r_row),
        .col      (r_col),
        .move     (move),
        .next_row (w_step_row),
        .next_col (w_step_col),
        .oob      (w_oob)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_tgt_row <= 4'd0;
            r_tgt_col <= 4'd0;
            r_last    <= 1'b0;
            r_steps   <= 9'd0;
            r_err     <= c_err_none;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_tgt_row <= w_tgt_row_nxt;
            r_tgt_col <= w_tgt_col_nxt;
            r_last    <= w_last_nxt;
            r_steps   <= w_steps_nxt;
            r_err     <= w_err_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_tgt_row_nxt = r_tgt_row;
        w_tgt_col_nxt = r_tgt_col;
        w_last_nxt    = r_last;
        w_steps_nxt   = r_steps;
        w_err_nxt     = r_err;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;

        case (r_state)
            ST_WAIT_MOVE: begin
                if (move_valid) begin
                    if (w_oob) begin
                        w_state_nxt = ST_FAIL;
                        w_err_nxt   = c_err_oob;
                        w_fail_nxt  = 1'b1;
                    end else if ((r_steps == c_last_step) && !last) begin
                        // One more validated move would exceed the budget
                        w_state_nxt = ST_FAIL;
                        w_err_nxt   = c_err_end;
                        w_fail_nxt  = 1'b1;
                    end else begin
                        w_tgt_row_nxt = w_step_row;
                        w_tgt_col_nxt = w_step_col;
                        w_last_nxt    = last;
                        w_state_nxt   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (maze_data) begin
                    w_state_nxt = ST_FAIL;
                    w_err_nxt   = c_err_wall;
                    w_fail_nxt  = 1'b1;
                end else begin
                    w_row_nxt   = r_tgt_row;
                    w_col_nxt   = r_tgt_col;
                    w_steps_nxt = r_steps + 9'd1;
                    if (!r_last) begin
                        w_state_nxt = ST_WAIT_MOVE;
                    end else if ((r_tgt_row == c_goal_row) && (r_tgt_col == c_goal_col)) begin
                        w_state_nxt = ST_PASS;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_err_nxt   = c_err_end;
                        w_fail_nxt  = 1'b1;
                    end
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // start overrides everything, including a move offered the same cycle
        if (start) begin
            w_state_nxt = ST_WAIT_MOVE;
            w_row_nxt   = 4'd0;
            w_col_nxt   = 4'd0;
            w_steps_nxt = 9'd0;
            w_err_nxt   = c_err_none;
            w_pass_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
        end
    end

    assign move_ready = (r_state == ST_WAIT_MOVE);
    assign busy       = (r_state == ST_WAIT_MOVE) || (r_state == ST_READ) ||
                        (r_state == ST_CHECK);
    // The memory samples the target during READ so data arrives in CHECK
    assign maze_addr  = (r_state == ST_READ) ? {r_tgt_row, r_tgt_col} : {r_row, r_col};
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign err_code   = r_err;
    assign step_count = r_steps;
    assign cur_row    = r_row;
    assign cur_col    = r_col;

endmodule
`default_nettype wire

// File: tb/tb_rat_path_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_path_checker
// Description : Self-checking bench for rat_path_checker: directed vector
//               table, hand-written multi-cycle sequences and randomized
//               paths compared with a behavioural path model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_path_checker;

    localparam int MAX_STEPS = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       move_valid;
    logic [1:0] move;
    logic       last;
    logic       move_ready;
    logic [7:0] maze_addr;
    logic       maze_data;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] err_code;
    logic [8:0] step_count;
    logic [3:0] cur_row;
    logic [3:0] cur_col;

    logic       maze    [0:255];
    logic [1:0] path_mv [0:299];
    int         path_len;
    int         n_err = 0;
    int         n_chk = 0;
    int         cyc   = 0;

    rat_path_checker #(
        .MAZE_DIM  (16),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .move       (move),
        .last       (last),
        .move_ready (move_ready),
        .maze_addr  (maze_addr),
        .maze_data  (maze_data),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code),
        .step_count (step_count),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clk = ~clk;

    // 256x1 maze memory, one-cycle synchronous read
    always @(posedge clk) maze_data <= maze[maze_addr];

    typedef struct {
        logic [15:0] moves;      // move i in bits [2i+1:2i]
        int          len;
        bit          has_wall;
        logic [7:0]  wall_addr;  // {row,col}
        bit          e_pass;
        bit          e_fail;
        logic [1:0]  e_err;
        int          e_steps;
        int          e_row;
        int          e_col;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic open_maze();
        for (int i = 0; i < 256; i++) maze[i] = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // st: 0 = handshake done, 1 = checker no longer busy, 2 = ready timeout
    task automatic send_move(input logic [1:0] m, input logic l, input int gap, output int st);
        int guard;
        for (int g = 0; g < gap; g++) begin
            move_valid = 1'b0;
            move       = 2'($urandom);
            last       = 1'($urandom);
            tick();
        end
        guard = 0;
        while (busy && !move_ready && guard < 10) begin
            tick();
            guard++;
        end
        if (!busy) begin
            st = 1;
            return;
        end
        if (!move_ready) begin
            st = 2;
            return;
        end
        move_valid = 1'b1;
        move       = m;
        last       = l;
        tick();
        move_valid = 1'b0;
        last       = 1'b0;
        st         = 0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 10) begin
            tick();
            guard++;
        end
        if (busy) chk("done_timeout", 32'(busy), 0);
    endtask

    task automatic run_path(input int gap_max);
        int st;
        pulse_start();
        for (int i = 0; i < path_len; i++) begin
            send_move(path_mv[i], (i == path_len - 1),
                      (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, st);
            if (st == 2) begin
                chk("ready_timeout", 32'(move_ready), 1);
                break;
            end
            if (st == 1) break;
        end
        wait_idle();
    endtask

    task automatic check_result(input string tag, input bit ep, input bit ef, input logic [1:0] ee,
                                input int es, input int er, input int ec);
        chk({tag, ".pass"},  32'(pass),       32'(ep));
        chk({tag, ".fail"},  32'(fail),       32'(ef));
        chk({tag, ".err"},   32'(err_code),   32'(ee));
        chk({tag, ".steps"}, 32'(step_count), 32'(es));
        chk({tag, ".row"},   32'(cur_row),    32'(er));
        chk({tag, ".col"},   32'(cur_col),    32'(ec));
    endtask

    // Behavioural model: walk the path on integer coordinates
    task automatic model_run(output bit ep, output bit ef, output logic [1:0] ee,
                             output int es, output int er, output int ec);
        int r, c, s, tr, tc;
        bit is_last;
        r = 0; c = 0; s = 0;
        ep = 1'b0; ef = 1'b0; ee = 2'd0;
        for (int i = 0; i < path_len; i++) begin
            is_last = (i == path_len - 1);
            tr = r + ((path_mv[i] == 2'd3) ? 1 : (path_mv[i] == 2'd0) ? -1 : 0);
            tc = c + ((path_mv[i] == 2'd1) ? 1 : (path_mv[i] == 2'd2) ? -1 : 0);
            if (tr < 0 || tr > 15 || tc < 0 || tc > 15) begin
                ef = 1'b1; ee = 2'd1; break;
            end
            if (s == MAX_STEPS - 1 && !is_last) begin
                ef = 1'b1; ee = 2'd3; break;
            end
            if (maze[tr * 16 + tc]) begin
                ef = 1'b1; ee = 2'd2; break;
            end
            r = tr; c = tc; s++;
            if (is_last) begin
                if (r == 15 && c == 15) ep = 1'b1;
                else begin ef = 1'b1; ee = 2'd3; end
            end
        end
        es = s; er = r; ec = c;
    endtask

    task automatic load_scenario1();
        for (int i = 0; i < 15; i++) path_mv[i] = 2'd3;
        for (int i = 15; i < 30; i++) path_mv[i] = 2'd1;
        path_len = 30;
    endtask

    task automatic scenario1(input string tag);
        int c0;
        open_maze();
        load_scenario1();
        c0 = cyc;
        run_path(0);
        check_result(tag, 1'b1, 1'b0, 2'd0, 30, 15, 15);
        // start edge plus 30 moves at 3 cycles each
        chk({tag, ".cycles"}, 32'(cyc - c0), 91);
    endtask

    initial begin
        bit         ep, ef;
        logic [1:0] ee;
        int         es, er, ec, st;

        vecs[0] = '{16'h0001, 1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1, 0, 1};
        vecs[1] = '{16'h0000, 1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 0, 0, 0};
        vecs[2] = '{16'h0002, 1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 0, 0, 0};
        vecs[3] = '{16'h0003, 1, 1'b1, 8'h10, 1'b0, 1'b1, 2'd2, 0, 0, 0};
        vecs[4] = '{16'h000D, 2, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 2, 1, 1};
        vecs[5] = '{16'h004F, 4, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 4, 1, 1};
        vecs[6] = '{16'h0035, 3, 1'b1, 8'h12, 1'b0, 1'b1, 2'd2, 2, 0, 2};
        vecs[7] = '{16'h00A7, 4, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 3, 1, 0};

        rst = 1'b0; start = 1'b0; move_valid = 1'b0; move = 2'd0; last = 1'b0;
        open_maze();

        // Reset state, before any clock edge
        #3;
        chk("rst.busy",  32'(busy),       0);
        chk("rst.ready", 32'(move_ready), 0);
        chk("rst.pass",  32'(pass),       0);
        chk("rst.fail",  32'(fail),       0);
        chk("rst.err",   32'(err_code),   0);
        chk("rst.steps", 32'(step_count), 0);
        chk("rst.pos",   32'({cur_row, cur_col}), 0);
        tick(); tick();
        rst = 1'b1;

        // Moves offered in IDLE are ignored
        move_valid = 1'b1; move = 2'd3; last = 1'b0;
        tick(); tick(); tick();
        chk("idle.busy",  32'(busy),       0);
        chk("idle.ready", 32'(move_ready), 0);
        chk("idle.pos",   32'({cur_row, cur_col}), 0);
        move_valid = 1'b0;

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            open_maze();
            if (vecs[v].has_wall) maze[vecs[v].wall_addr] = 1'b1;
            path_len = vecs[v].len;
            for (int i = 0; i < vecs[v].len; i++) begin
                logic [15:0] mv;
                mv = vecs[v].moves >> (2 * i);
                path_mv[i] = mv[1:0];
            end
            run_path(0);
            check_result($sformatf("vec%0d", v), vecs[v].e_pass, vecs[v].e_fail,
                         vecs[v].e_err, vecs[v].e_steps, vecs[v].e_row, vecs[v].e_col);
        end

        // Scenario 1: full path to the goal
        scenario1("sc1");

        // Scenario 2: out of bounds first move, later moves ignored
        open_maze();
        path_mv[0] = 2'd0; path_len = 1;
        run_path(0);
        check_result("sc2", 1'b0, 1'b1, 2'd1, 0, 0, 0);
        move_valid = 1'b1; move = 2'd3; last = 1'b1;
        tick(); tick(); tick();
        move_valid = 1'b0; last = 1'b0;
        chk("sc2.ignored_ready", 32'(move_ready), 0);
        check_result("sc2.after", 1'b0, 1'b1, 2'd1, 0, 0, 0);

        // Scenario 3: wall hit timing
        open_maze();
        maze[8'h10] = 1'b1;
        pulse_start();
        move_valid = 1'b1; move = 2'd3; last = 1'b0;
        tick();
        move_valid = 1'b0;
        chk("sc3.fail_read", 32'(fail), 0);
        tick();
        chk("sc3.fail_check", 32'(fail), 0);
        tick();
        check_result("sc3", 1'b0, 1'b1, 2'd2, 0, 0, 0);

        // Scenario 5: restart mid-path, then start colliding with a move
        open_maze();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_move((i < 3) ? 2'd3 : 2'd1, 1'b0, 0, st);
            if (st != 0) chk("sc5.handshake", 32'(st), 0);
        end
        pulse_start();
        chk("sc5.busy",  32'(busy),       1);
        chk("sc5.steps", 32'(step_count), 0);
        chk("sc5.pos",   32'({cur_row, cur_col}), 0);
        start = 1'b1; move_valid = 1'b1; move = 2'd3; last = 1'b0;
        tick();
        start = 1'b0; move_valid = 1'b0;
        chk("sc5.collide_ready", 32'(move_ready), 1);
        chk("sc5.collide_addr",  32'(maze_addr),  0);
        scenario1("sc5");

        // Scenario 6: asynchronous reset while in READ
        open_maze();
        pulse_start();
        move_valid = 1'b1; move = 2'd1; last = 1'b0;
        tick();
        move_valid = 1'b0;
        chk("sc6.in_read", 32'(maze_addr), 32'h01);
        #2 rst = 1'b0;
        #1;
        chk("sc6.busy",  32'(busy),       0);
        chk("sc6.ready", 32'(move_ready), 0);
        chk("sc6.flags", 32'({pass, fail, err_code}), 0);
        chk("sc6.steps", 32'(step_count), 0);
        chk("sc6.pos",   32'({cur_row, cur_col}), 0);
        tick();
        rst = 1'b1;
        move_valid = 1'b1; move = 2'd3;
        tick(); tick(); tick();
        move_valid = 1'b0;
        chk("sc6.ignored", 32'({busy, move_ready, step_count}), 0);
        path_mv[0] = 2'd1; path_len = 1;
        run_path(0);
        check_result("sc6.recover", 1'b0, 1'b1, 2'd3, 1, 0, 1);

        // Step budget: 256th move without last overflows; with last it counts
        open_maze();
        for (int i = 0; i < 255; i++) path_mv[i] = (i % 2 == 0) ? 2'd1 : 2'd2;
        path_mv[255] = 2'd3; path_mv[256] = 2'd3;
        path_len = 257;
        run_path(0);
        check_result("ovf", 1'b0, 1'b1, 2'd3, 255, 0, 1);
        path_len = 256;
        run_path(0);
        check_result("ovf_last", 1'b0, 1'b1, 2'd3, 256, 1, 1);

        // Randomized paths against the model
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 256; i++)
                maze[i] = ($urandom_range(0, 99) < ((t % 2 == 0) ? 3 : 10));
            maze[0] = 1'b0;
            if (t % 2 == 0) begin
                // Monotonic down/right path: reaches the goal unless a wall blocks it
                for (int i = 0; i < 30; i++) path_mv[i] = (i < 15) ? 2'd3 : 2'd1;
                for (int i = 29; i > 0; i--) begin
                    int j;
                    logic [1:0] tmp;
                    j = $urandom_range(0, i);
                    tmp = path_mv[i]; path_mv[i] = path_mv[j]; path_mv[j] = tmp;
                end
                path_len = 30;
            end else begin
                path_len = $urandom_range(1, 20);
                for (int i = 0; i < path_len; i++) path_mv[i] = 2'($urandom);
            end
            model_run(ep, ef, ee, es, er, ec);
            run_path(2);
            check_result($sformatf("rnd%0d", t), ep, ef, ee, es, er, ec);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
